// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  // Fetch FSM: FETCH issues requests, DRAIN swallows stale responses after a redirect
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush.
// Latency: push visible at pop_data the cycle after; head read is combinational.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write; no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush behaves like a reset of the bookkeeping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order word requests, queues {pc, instr} for decode.
// Latency: grant to instr_valid_o is memory response latency + 1 cycle.
// Backpressure: requests are credit-limited so queue entries plus in-flight requests never exceed DEPTH.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  localparam int                    CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]           CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(INSTR_BYTES);

  fetch_state_e          state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;

  logic [CW-1:0]           q_count;
  logic                    q_full;
  logic                    q_empty;
  logic [2*DATA_WIDTH-1:0] q_head;
  logic                    q_pop;

  logic                  issue;
  logic                  rsp_take;
  logic [DATA_WIDTH-1:0] rsp_pc;
  logic [CW:0]           credit_used;
  logic [CW:0]           drop_sum;
  logic [CW-1:0]         redirect_drop;
  logic [1:0]            unused_pc_bits;

  // Low address bits of a redirect target are forced to zero
  assign unused_pc_bits = redirect_pc_i[1:0];

  // Credit: a request is only issued if its response is guaranteed a queue slot.
  // q_count is registered, so instr_ready_i has no path into imem_req_o.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_o  = !rst && (state == FETCH) && !redirect_i && !q_full
                       && (credit_used < CREDIT_MAX);
  assign imem_addr_o = fetch_pc;
  assign issue       = imem_req_o && imem_gnt_i;

  // Responses return in order, so the oldest outstanding request's PC is
  // fetch_pc minus one word per request still in flight.
  assign rsp_pc   = fetch_pc - DATA_WIDTH'(outstanding) * STEP;
  assign rsp_take = !rst && !redirect_i && imem_rvalid_i
                    && (drop_cnt == '0) && (outstanding != '0);

  // Everything in flight at a redirect is stale, including a same-cycle grant;
  // a same-cycle response retires one of them immediately.
  assign drop_sum      = {1'b0, drop_cnt} + {1'b0, outstanding} + {{CW{1'b0}}, issue};
  assign redirect_drop = (imem_rvalid_i && (drop_sum != '0)) ? CW'(drop_sum - (CW+1)'(1))
                                                             : CW'(drop_sum);

  assign q_pop = instr_ready_i && !q_empty;

  sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_take),
    .push_data ({rsp_pc, imem_rdata_i}),
    .pop       (q_pop),
    .flush     (redirect_i),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Head presented straight from queue storage; zeroed when nothing valid
  assign instr_valid_o = !rst && !q_empty;
  assign instr_o       = instr_valid_o ? q_head[DATA_WIDTH-1:0]            : '0;
  assign instr_pc_o    = instr_valid_o ? q_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;

  // Fetch FSM with PC, in-flight and drop bookkeeping; redirect overrides the state actions
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      outstanding <= '0;
      drop_cnt    <= redirect_drop;
      state       <= (redirect_drop != '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (issue) begin
            fetch_pc <= fetch_pc + STEP;
          end
          case ({issue, rsp_take})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
          endcase
        end
        DRAIN: begin
          if (imem_rvalid_i && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) begin
              state <= FETCH;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
